// File: rtl/sprite_xform_pkg.sv
// Shared types and constants for the sprite orientation transform.
// Holds rotation encodings, the orient_t bundle and the default FRAME_DIV.
package sprite_pkg;

    localparam logic [1:0] ROT_N = 2'd0;
    localparam logic [1:0] ROT_E = 2'd1;
    localparam logic [1:0] ROT_S = 2'd2;
    localparam logic [1:0] ROT_W = 2'd3;

    localparam int FRAME_DIV_DEF = 30;

    typedef struct packed {
        logic       mir;
        logic [1:0] rot;
    } orient_t;

endpackage

// File: rtl/sprite_xform_if.sv
// Pixel-coordinate in / ROM-address out bundle for sprite_xform.
// master: drives pixel_h/pixel_v/pixel_valid; slave: returns addr/addr_valid.
interface sprite_xform_if #(
    parameter int COORD_W = 4
) ();
    localparam int ADDR_W = 2 * COORD_W;

    logic [COORD_W-1:0] pixel_h;
    logic [COORD_W-1:0] pixel_v;
    logic               pixel_valid;
    logic [ADDR_W-1:0]  addr;
    logic               addr_valid;

    modport master (
        output pixel_h,
        output pixel_v,
        output pixel_valid,
        input  addr,
        input  addr_valid
    );

    modport slave (
        input  pixel_h,
        input  pixel_v,
        input  pixel_valid,
        output addr,
        output addr_valid
    );
endinterface

// File: rtl/sprite_xform_map.sv
// Combinational sprite coordinate -> ROM address mapper for 8 orientations.
// Ports: h, v (coords), o (orient_t), addr (2*COORD_W bits).
module sprite_xform_map
    import sprite_pkg::*;
#(
    parameter int COORD_W = 4
) (
    input  logic [COORD_W-1:0]   h,
    input  logic [COORD_W-1:0]   v,
    input  orient_t              o,
    output logic [2*COORD_W-1:0] addr
);

    logic [COORD_W-1:0] hm;

    // Mirror is applied before rotation.
    assign hm = o.mir ? ~h : h;

    always_comb begin
        addr = '0;
        unique case (o.rot)
            ROT_N: addr = {v, hm};
            ROT_E: addr = {~hm, v};
            ROT_S: addr = {~v, ~hm};
            ROT_W: addr = {hm, ~v};
        endcase
    end

endmodule

// File: rtl/sprite_xform.sv
// Sprite orientation stage: coordinate->ROM address, inversion, auto-rotate.
// Ports: vgaclk, reset_n (sync, low), pix (slave bus), frame_tick, btn_*,
// inv, orient {mir,rot}, auto_on. Define SPRITE_XFORM_FRAME_SYNC_EN to
// hold button changes in pending registers until frame_tick.
module sprite_xform
    import sprite_pkg::*;
#(
    parameter int COORD_W   = 4,
    parameter int FRAME_DIV = FRAME_DIV_DEF
) (
    input  logic           vgaclk,
    input  logic           reset_n,
    sprite_xform_if.slave  pix,
    input  logic           frame_tick,
    input  logic           btn_rot_cw,
    input  logic           btn_rot_ccw,
    input  logic           btn_mirror,
    input  logic           btn_inv,
    input  logic           btn_auto,
    output logic           inv,
    output logic [2:0]     orient,
    output logic           auto_on
);

    localparam int ADDR_W = 2 * COORD_W;
    localparam logic [7:0] CNT_LAST = 8'(FRAME_DIV - 1);

    orient_t           cur;
    logic [7:0]        frame_cnt;
    logic              auto_step;
    logic [1:0]        delta;
    logic [ADDR_W-1:0] map_addr;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;

    assign orient = cur;

    assign auto_step = auto_on && frame_tick && (frame_cnt == CNT_LAST);

    // Net rotation this cycle: cw/ccw cancel, auto step adds +1 on top.
    always_comb begin
        delta = 2'd0;
        if (btn_rot_cw && !btn_rot_ccw) begin
            delta = 2'd1;
        end else if (btn_rot_ccw && !btn_rot_cw) begin
            delta = 2'd3;
        end
        if (auto_step) begin
            delta = delta + 2'd1;
        end
    end

    always_ff @(posedge vgaclk) begin
        if (!reset_n) begin
            auto_on   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (btn_auto) begin
                auto_on <= !auto_on;
            end
            if (btn_auto && auto_on) begin
                frame_cnt <= 8'd0;
            end else if (auto_step) begin
                frame_cnt <= 8'd0;
            end else if (auto_on && frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef SPRITE_XFORM_FRAME_SYNC_EN
    // Pending registers track the absolute next orientation, so a commit
    // simply copies them (including any same-cycle button pulse).
    logic [1:0] pend_rot;
    logic       pend_mir;
    logic       pend_inv;
    logic [1:0] pend_rot_nxt;
    logic       pend_mir_nxt;
    logic       pend_inv_nxt;

    assign pend_rot_nxt = pend_rot + delta;
    assign pend_mir_nxt = pend_mir ^ btn_mirror;
    assign pend_inv_nxt = pend_inv ^ btn_inv;

    always_ff @(posedge vgaclk) begin
        if (!reset_n) begin
            pend_rot <= ROT_N;
            pend_mir <= 1'b0;
            pend_inv <= 1'b0;
            cur      <= '0;
            inv      <= 1'b0;
        end else begin
            pend_rot <= pend_rot_nxt;
            pend_mir <= pend_mir_nxt;
            pend_inv <= pend_inv_nxt;
            if (frame_tick) begin
                cur.rot <= pend_rot_nxt;
                cur.mir <= pend_mir_nxt;
                inv     <= pend_inv_nxt;
            end
        end
    end
`else
    always_ff @(posedge vgaclk) begin
        if (!reset_n) begin
            cur <= '0;
            inv <= 1'b0;
        end else begin
            cur.rot <= cur.rot + delta;
            cur.mir <= cur.mir ^ btn_mirror;
            inv     <= inv ^ btn_inv;
        end
    end
`endif

    sprite_xform_map #(
        .COORD_W(COORD_W)
    ) u_map (
        .h    (pix.pixel_h),
        .v    (pix.pixel_v),
        .o    (cur),
        .addr (map_addr)
    );

    // Address holds its last value while pixel_valid is low.
    always_ff @(posedge vgaclk) begin
        if (!reset_n) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pix.pixel_valid;
            if (pix.pixel_valid) begin
                addr_q <= map_addr;
            end
        end
    end

    assign pix.addr       = addr_q;
    assign pix.addr_valid = valid_q;

endmodule

// File: tb/tb_sprite_xform.sv
// Directed testbench for sprite_xform (FRAME_DIV=3).
// Table of committed orientation vectors plus hand-written sequences.
module tb_sprite_xform;

    logic       vgaclk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       btn_rot_cw;
    logic       btn_rot_ccw;
    logic       btn_mirror;
    logic       btn_inv;
    logic       btn_auto;
    logic       inv;
    logic [2:0] orient;
    logic       auto_on;

    int n_run  = 0;
    int n_fail = 0;

    sprite_xform_if #(.COORD_W(4)) pix ();

    sprite_xform #(
        .COORD_W  (4),
        .FRAME_DIV(3)
    ) dut (
        .vgaclk     (vgaclk),
        .reset_n    (reset_n),
        .pix        (pix),
        .frame_tick (frame_tick),
        .btn_rot_cw (btn_rot_cw),
        .btn_rot_ccw(btn_rot_ccw),
        .btn_mirror (btn_mirror),
        .btn_inv    (btn_inv),
        .btn_auto   (btn_auto),
        .inv        (inv),
        .orient     (orient),
        .auto_on    (auto_on)
    );

    always #5 vgaclk = ~vgaclk;

    typedef struct {
        logic       cw;
        logic       ccw;
        logic       mir;
        logic       iv;
        logic [3:0] h;
        logic [3:0] v;
        logic [2:0] o;
        logic       inv;
        logic [7:0] a;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock; pulses are dropped just after the edge.
    task automatic cyc();
        @(posedge vgaclk);
        #1;
        btn_rot_cw  = 1'b0;
        btn_rot_ccw = 1'b0;
        btn_mirror  = 1'b0;
        btn_inv     = 1'b0;
        btn_auto    = 1'b0;
        frame_tick  = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        cyc();
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 0, 4'h3, 4'h5, 3'b001, 0, 8'hC5};
        tbl[1] = '{1, 0, 0, 0, 4'h3, 4'h5, 3'b010, 0, 8'hAC};
        tbl[2] = '{1, 0, 0, 0, 4'h1, 4'h2, 3'b011, 0, 8'h1D};
        tbl[3] = '{1, 0, 0, 0, 4'hF, 4'h0, 3'b000, 0, 8'h0F};
        tbl[4] = '{0, 0, 1, 0, 4'h3, 4'h5, 3'b100, 0, 8'h5C};
        tbl[5] = '{1, 1, 0, 1, 4'h3, 4'h5, 3'b100, 1, 8'h5C};
        tbl[6] = '{0, 1, 0, 0, 4'h3, 4'h5, 3'b111, 1, 8'hCA};
        tbl[7] = '{0, 1, 0, 1, 4'h3, 4'h5, 3'b110, 0, 8'hA3};
        tbl[8] = '{0, 1, 1, 0, 4'h3, 4'h5, 3'b001, 0, 8'hC5};
        tbl[9] = '{0, 1, 0, 0, 4'hA, 4'h7, 3'b000, 0, 8'h7A};

        reset_n         = 1'b0;
        frame_tick      = 1'b0;
        btn_rot_cw      = 1'b0;
        btn_rot_ccw     = 1'b0;
        btn_mirror      = 1'b0;
        btn_inv         = 1'b0;
        btn_auto        = 1'b0;
        pix.pixel_h     = 4'h0;
        pix.pixel_v     = 4'h0;
        pix.pixel_valid = 1'b0;
        cyc();
        cyc();
        chk("rst_addr", 32'(pix.addr), 32'h0);
        chk("rst_valid", 32'(pix.addr_valid), 32'h0);
        chk("rst_orient", 32'(orient), 32'h0);
        chk("rst_inv", 32'(inv), 32'h0);
        chk("rst_auto", 32'(auto_on), 32'h0);

        reset_n         = 1'b1;
        pix.pixel_h     = 4'h3;
        pix.pixel_v     = 4'h5;
        pix.pixel_valid = 1'b1;
        cyc();
        chk("first_addr", 32'(pix.addr), 32'h53);
        chk("first_valid", 32'(pix.addr_valid), 32'h1);

        btn_rot_cw = 1'b1;
        cyc();
        cyc();
`ifdef SPRITE_XFORM_FRAME_SYNC_EN
        chk("midframe_orient", 32'(orient), 32'h0);
        chk("midframe_addr", 32'(pix.addr), 32'h53);
        tick();
`endif
        chk("cw_orient", 32'(orient), 32'h1);
        chk("cw_addr", 32'(pix.addr), 32'hC5);

        pix.pixel_valid = 1'b0;
        pix.pixel_h     = 4'h0;
        cyc();
        chk("hold_addr", 32'(pix.addr), 32'hC5);
        chk("hold_valid", 32'(pix.addr_valid), 32'h0);
        pix.pixel_h     = 4'h3;
        pix.pixel_valid = 1'b1;

        btn_rot_ccw = 1'b1;
        tick();
        chk("back_orient", 32'(orient), 32'h0);
        chk("back_addr", 32'(pix.addr), 32'h53);

        for (int i = 0; i < 10; i++) begin
            pix.pixel_h = tbl[i].h;
            pix.pixel_v = tbl[i].v;
            btn_rot_cw  = tbl[i].cw;
            btn_rot_ccw = tbl[i].ccw;
            btn_mirror  = tbl[i].mir;
            btn_inv     = tbl[i].iv;
            tick();
            chk($sformatf("vec%0d_orient", i), 32'(orient), 32'(tbl[i].o));
            chk($sformatf("vec%0d_inv", i), 32'(inv), 32'(tbl[i].inv));
            chk($sformatf("vec%0d_addr", i), 32'(pix.addr), 32'(tbl[i].a));
        end

        pix.pixel_h = 4'h3;
        pix.pixel_v = 4'h5;
        btn_mirror  = 1'b1;
        cyc();
        btn_rot_cw  = 1'b1;
        cyc();
        btn_rot_cw  = 1'b1;
        cyc();
        tick();
        chk("mircw2_orient", 32'(orient), 32'h6);
        chk("mircw2_addr", 32'(pix.addr), 32'hA3);

        reset_n = 1'b0;
        cyc();
        chk("rst2_valid", 32'(pix.addr_valid), 32'h0);
        chk("rst2_orient", 32'(orient), 32'h0);
        reset_n = 1'b1;

        btn_auto = 1'b1;
        cyc();
        chk("auto_on", 32'(auto_on), 32'h1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("auto_tick%0d", k), 32'(orient),
                (k >= 6) ? 32'h2 : (k >= 3) ? 32'h1 : 32'h0);
        end
        btn_auto = 1'b1;
        cyc();
        chk("auto_off", 32'(auto_on), 32'h0);
        tick();
        tick();
        btn_auto = 1'b1;
        cyc();
        tick();
        chk("auto_cleared", 32'(orient), 32'h2);

        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        btn_inv = 1'b1;
        cyc();
        reset_n = 1'b0;
        cyc();
        chk("rstinv_inv", 32'(inv), 32'h0);
        chk("rstinv_orient", 32'(orient), 32'h0);
        chk("rstinv_valid", 32'(pix.addr_valid), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("rstinv_lost", 32'(inv), 32'h0);
        chk("rstinv_addr", 32'(pix.addr), 32'h53);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
